// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared types and glyph table for the seven-segment scan driver
//
// Purpose: segment bit order, the 16-entry hex glyph table (active-high,
// bit set = segment lit) and the all-segments-off pin pattern (active-low).
package seg7_pkg;

  // Segment bit positions inside a pattern word.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_COUNT = SEG_G + 1;

  typedef logic [SEG_COUNT-1:0] seg_t;

  // Active-low pin pattern with every segment dark.
  localparam seg_t SEG_OFF_N = 7'h7F;

  // Glyphs 0-9, A, b, C, d, E, F; active-high, indexed by nibble.
  localparam seg_t GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - value-load bus between a register source and the scan driver
//
// Purpose: groups the shadow-load strobe, its payload and the pending flag.
// Signals:
//   load     - one-cycle strobe capturing value/dp_in/blank_lz into the shadow
//   value    - hex nibbles, digit 0 in bits [3:0]
//   dp_in    - decimal-point request per digit
//   blank_lz - leading-zero blanking enable
//   pending  - high while a captured value waits for a frame boundary
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    blank_lz;
  logic                    pending;

  modport master (output load, output value, output dp_in, output blank_lz, input pending);
  modport slave  (input load, input value, input dp_in, input blank_lz, output pending);
endinterface

// File: rtl/seg7_scan_driver_hex_decoder.sv
// rtl/seg7_scan_driver_hex_decoder.sv - combinational hex nibble to active-low segment decoder
//
// Purpose: maps one nibble to its hex glyph.
// Ports:
//   nibble - 4-bit digit value
//   seg_n  - 7-bit active-low segment pattern, bit 0 = a
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_n
);

  assign seg_n = ~GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit common-anode seven-segment driver
//
// Purpose: scans N_DIGITS digits with a per-slot prescaler, anti-ghosting dead
// time, leading-zero blanking and a shadow register that only reaches the
// display at frame boundaries so a frame is never torn.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   enable      - scanning enable; low blanks the display and parks the scan
//   bus         - load bus (load, value, dp_in, blank_lz in; pending out)
//   seg, dp, an - active-low segment, decimal point and anode pins (registered)
//   frame_done  - one-cycle pulse after the last digit's slot ends
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  seg7_scan_driver_if.slave   bus,
  output seg_t                seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an,
  output logic                frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   shadow_value;
  logic [N_DIGITS-1:0]     shadow_dp;
  logic                    shadow_blz;
  logic [4*N_DIGITS-1:0]   disp_value;
  logic [N_DIGITS-1:0]     disp_dp;
  logic                    disp_blz;
  logic                    pending_q;

  logic                    boundary;
  logic                    xfer;
  logic [N_DIGITS-1:0]     blank_mask;
  logic                    still_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  seg_t                    dec_seg;

  assign boundary = enable && (presc == PRESC_LAST) && (idx == IDX_LAST);
  // While disabled nothing is on screen, so a waiting value can go straight in.
  assign xfer     = pending_q && (boundary || !enable);
  assign bus.pending = pending_q;

  // Walk down from the most significant digit; blanking continues only while
  // every digit seen so far is zero. Digit 0 is deliberately outside the loop.
  always_comb begin
    blank_mask = '0;
    still_zero = disp_blz;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (still_zero && (disp_value[4*k +: 4] == 4'h0)) begin
        blank_mask[k] = 1'b1;
      end else begin
        still_zero = 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = disp_value[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  seg7_hex_decoder u_dec (
    .nibble (cur_nib),
    .seg_n  (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blz   <= 1'b0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_blz     <= 1'b0;
      pending_q    <= 1'b0;
      frame_done   <= 1'b0;
      seg          <= SEG_OFF_N;
      dp           <= 1'b1;
      an           <= '1;
    end else begin
      frame_done <= boundary;

      if (!enable) begin
        presc <= '0;
        idx   <= '0;
      end else if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      // The transfer reads the shadow before this cycle's load overwrites it.
      if (xfer) begin
        disp_value <= shadow_value;
        disp_dp    <= shadow_dp;
        disp_blz   <= shadow_blz;
      end

      if (bus.load) begin
        shadow_value <= bus.value;
        shadow_dp    <= bus.dp_in;
        shadow_blz   <= bus.blank_lz;
        pending_q    <= 1'b1;
      end else if (xfer) begin
        pending_q    <= 1'b0;
      end

      // seg/dp follow the slot from its first cycle; only the anode waits
      // out the dead window.
      if (!enable) begin
        seg <= SEG_OFF_N;
        dp  <= 1'b1;
        an  <= '1;
      end else begin
        seg <= cur_blank ? SEG_OFF_N : dec_seg;
        dp  <= ~cur_dp;
        an  <= (presc < DEAD_END) ? '1 : ~(N_DIGITS'(1) << idx);
      end
    end
  end

endmodule
